// File: rtl/sr_button_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_button_debouncer_if
// Brief    : Button inputs and conditioned SR pulse outputs of the debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_button_debouncer_if;
    logic btn_set;
    logic btn_rst;
    logic S;
    logic R;
    logic set_level;
    logic rst_level;
    logic conflict;

    // The master drives the raw buttons and observes the conditioned outputs.
    modport master (
        output btn_set,
        output btn_rst,
        input  S,
        input  R,
        input  set_level,
        input  rst_level,
        input  conflict
    );

    modport slave (
        input  btn_set,
        input  btn_rst,
        output S,
        output R,
        output set_level,
        output rst_level,
        output conflict
    );
endinterface
`default_nettype wire

// File: rtl/sr_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : sr_button_debouncer
// Brief    : Two-channel synchronizer/debouncer producing interlocked S/R pulses.
// Revision : 1.0 - initial release
// ============================================================================
module sr_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sr_button_debouncer_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Channel 0 is the set button, channel 1 the reset button.
    logic [1:0]           w_btn;
    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    logic [1:0]           r_level;
    logic [1:0]           w_level_next;
    logic [1:0]           w_rise;
    logic [CNT_WIDTH-1:0] r_cnt      [2];
    logic [CNT_WIDTH-1:0] w_cnt_next [2];
    logic                 r_s;
    logic                 r_r;
    logic                 r_conflict;
    logic                 w_s;
    logic                 w_r;
    logic                 w_conflict;

    assign w_btn = {bus.btn_rst, bus.btn_set};

    // Any sample matching the current level restarts the qualification run.
    always_comb begin
        w_level_next = r_level;
        for (int ch = 0; ch < 2; ch++) begin
            w_cnt_next[ch] = '0;
            if (r_sync2[ch] != r_level[ch]) begin
                if (r_cnt[ch] == C_CNT_LAST) begin
                    w_level_next[ch] = r_sync2[ch];
                end else begin
                    w_cnt_next[ch] = r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    assign w_rise = w_level_next & ~r_level;

    // A press is only forwarded when the opposite channel is idle and not rising.
    assign w_s        = w_rise[0] & ~w_level_next[1] & ~w_rise[1];
    assign w_r        = w_rise[1] & ~w_level_next[0] & ~w_rise[0];
    assign w_conflict = (w_rise[0] & (w_level_next[1] | w_rise[1]))
                      | (w_rise[1] & (w_level_next[0] | w_rise[0]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_level    <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            r_sync1    <= w_btn;
            r_sync2    <= r_sync1;
            r_level    <= w_level_next;
            r_s        <= w_s;
            r_r        <= w_r;
            r_conflict <= w_conflict;
            for (int ch = 0; ch < 2; ch++) begin
                r_cnt[ch] <= w_cnt_next[ch];
            end
        end
    end

    assign bus.S         = r_s;
    assign bus.R         = r_r;
    assign bus.set_level = r_level[0];
    assign bus.rst_level = r_level[1];
    assign bus.conflict  = r_conflict;
endmodule
`default_nettype wire

// File: tb/tb_sr_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_button_debouncer
// Brief    : Directed self-checking bench with a sliding-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_button_debouncer;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    sr_button_debouncer_if bus ();

    sr_button_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (16)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level flips once the last D synchronized samples all disagree with it.
    logic m_s1  [2];
    logic m_s2  [2];
    logic m_lev [2];
    logic m_win [2][D];
    logic m_S, m_R, m_C;
    logic m_valid;

    initial begin
        cyc     = 0;
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        logic old_lev [2];
        logic nl      [2];
        logic rise    [2];
        logic raw     [2];
        logic all_diff;
        cyc = cyc + 1;
        raw[0] = bus.btn_set;
        raw[1] = bus.btn_rst;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c]  = 1'b0;
                m_s2[c]  = 1'b0;
                m_lev[c] = 1'b0;
                for (int i = 0; i < D; i++) m_win[c][i] = 1'b0;
            end
            m_S = 1'b0; m_R = 1'b0; m_C = 1'b0;
            m_valid = 1'b1;
        end else begin
            for (int c = 0; c < 2; c++) begin
                old_lev[c] = m_lev[c];
                for (int i = D - 1; i > 0; i--) m_win[c][i] = m_win[c][i-1];
                m_win[c][0] = m_s2[c];
                all_diff = 1'b1;
                for (int i = 0; i < D; i++) if (m_win[c][i] == old_lev[c]) all_diff = 1'b0;
                nl[c]   = all_diff ? ~old_lev[c] : old_lev[c];
                rise[c] = !old_lev[c] && nl[c];
                m_lev[c] = nl[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
            end
            m_S = rise[0] && !nl[1];
            m_R = rise[1] && !nl[0];
            m_C = (rise[0] && nl[1]) || (rise[1] && nl[0]);
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Event statistics gathered from the DUT for the literal checks.
    int   s_cnt, r_cnt, c_cnt, s_cyc, r_cyc, c_cyc, set_rise_cyc, rst_rise_cyc;
    logic prev_set, prev_rst;

    task automatic clr_stats();
        s_cnt = 0; r_cnt = 0; c_cnt = 0;
        s_cyc = -1; r_cyc = -1; c_cyc = -1;
        set_rise_cyc = -1; rst_rise_cyc = -1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        prev_set = 1'b0;
        prev_rst = 1'b0;
        clr_stats();
    end

    always begin
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("S",         bus.S,         m_S);
            chk("R",         bus.R,         m_R);
            chk("conflict",  bus.conflict,  m_C);
            chk("set_level", bus.set_level, m_lev[0]);
            chk("rst_level", bus.rst_level, m_lev[1]);
            chk("S_and_R",   bus.S & bus.R, 1'b0);
            if (bus.S === 1'b1) begin s_cnt++; s_cyc = cyc; end
            if (bus.R === 1'b1) begin r_cnt++; r_cyc = cyc; end
            if (bus.conflict === 1'b1) begin c_cnt++; c_cyc = cyc; end
            if (bus.set_level === 1'b1 && !prev_set) set_rise_cyc = cyc;
            if (bus.rst_level === 1'b1 && !prev_rst) rst_rise_cyc = cyc;
            prev_set = bus.set_level;
            prev_rst = bus.rst_level;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int   k;
        logic pat [7];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rst_n       = 1'b0;
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;

        // Reset held while buttons toggle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.btn_set = ~bus.btn_set;
            bus.btn_rst = bus.btn_set;
            chk("reset_set_level", bus.set_level, 1'b0);
            chk("reset_S",         bus.S,         1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.btn_set = 1'b0; bus.btn_rst = 1'b0;
        clr_stats();
        wait_cycles(8);
        chk_int("idle_S_count", s_cnt, 0);
        chk_int("idle_R_count", r_cnt, 0);
        chk_int("idle_conflict_count", c_cnt, 0);

        // Clean press
        clr_stats();
        bus.btn_set = 1'b1; k = cyc + 1;
        wait_cycles(20);
        chk_int("press_level_edge", set_rise_cyc, k + 5);
        chk_int("press_S_edge",     s_cyc,        k + 5);
        chk_int("press_S_count",    s_cnt,        1);
        chk_int("press_R_count",    r_cnt,        0);
        bus.btn_set = 1'b0;
        wait_cycles(10);

        // Bounce then steady high
        clr_stats();
        for (int i = 0; i < 7; i++) begin
            bus.btn_set = pat[i];
            if (i == 6) k = cyc + 1;
            @(negedge clk);
        end
        wait_cycles(15);
        chk_int("bounce_level_edge", set_rise_cyc, k + 5);
        chk_int("bounce_S_count",    s_cnt,        1);
        bus.btn_set = 1'b0;
        wait_cycles(10);

        // Interlock: set pressed while reset held
        clr_stats();
        bus.btn_rst = 1'b1;
        wait_cycles(10);
        chk_int("lock_R_count", r_cnt, 1);
        clr_stats();
        bus.btn_set = 1'b1; k = cyc + 1;
        wait_cycles(10);
        chk_int("lock_S_count",        s_cnt, 0);
        chk_int("lock_R_count2",       r_cnt, 0);
        chk_int("lock_conflict_count", c_cnt, 1);
        chk_int("lock_conflict_edge",  c_cyc, k + 5);
        clr_stats();
        bus.btn_rst = 1'b0;
        wait_cycles(10);
        bus.btn_set = 1'b0;
        wait_cycles(10);
        chk_int("release_S_count",        s_cnt, 0);
        chk_int("release_R_count",        r_cnt, 0);
        chk_int("release_conflict_count", c_cnt, 0);

        // Simultaneous press
        clr_stats();
        bus.btn_set = 1'b1; bus.btn_rst = 1'b1; k = cyc + 1;
        wait_cycles(12);
        chk_int("simul_set_edge",       set_rise_cyc, k + 5);
        chk_int("simul_rst_edge",       rst_rise_cyc, k + 5);
        chk_int("simul_S_count",        s_cnt,        0);
        chk_int("simul_R_count",        r_cnt,        0);
        chk_int("simul_conflict_count", c_cnt,        1);
        bus.btn_set = 1'b0; bus.btn_rst = 1'b0;
        wait_cycles(10);

        // Reset mid-count with reset button held
        clr_stats();
        bus.btn_rst = 1'b1; k = cyc + 1;
        wait_cycles(2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(12);
        chk_int("midrst_R_edge",  r_cyc, k + 8);
        chk_int("midrst_R_count", r_cnt, 1);
        bus.btn_rst = 1'b0;
        wait_cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sr_button_debouncer.md
Name: sr_button_debouncer

Overview:
- Conditions two raw push-button inputs (set button, reset button) into clean, single-cycle S and R pulses for the downstream SR flip-flop.
- Each channel has a 2-FF synchronizer, a counter-based debounce filter and a rising-edge detector.
- An interlock guarantees S and R are never high in the same cycle, so the SR flip-flop never enters its undefined state.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized input must differ from the debounced level before the level is accepted (legal range >= 2).
- CNT_WIDTH, 16, counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- btn_set  input  1  raw, asynchronous, bouncy set button.
- btn_rst  input  1  raw, asynchronous, bouncy reset button.
- S  output  1  one-cycle set pulse to the SR flip-flop.
- R  output  1  one-cycle reset pulse to the SR flip-flop.
- set_level  output  1  debounced level of btn_set.
- rst_level  output  1  debounced level of btn_rst.
- conflict  output  1  one-cycle flag when a press is suppressed by the interlock.

Behaviour:
- Reset: the interface is one clock with a synchronous, active-low reset. When rst_n=0 at a rising clk edge, all sync FFs, counters, set_level, rst_level, S, R and conflict go to 0. There is no asynchronous path. Reset asserted mid-count discards the partial count. Reset asserted while a button is held: after release of rst_n the held button is re-qualified from scratch, giving a fresh rising edge and a pulse.
- Synchronizer, per channel: sync1 <= btn; sync2 <= sync1.
- Debounce, per channel, counter cnt:
  - If sync2 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the current level before the count completes clears cnt. Only an uninterrupted run is accepted.
- Latency: if edge k is the first edge to sample a new raw value that then stays stable, the level changes at edge k+DEBOUNCE_CYCLES+1. With the default of 4, that is edge k+5.
- Rise detection: set_rise is true at an edge where set_level goes 0->1. rst_rise is defined the same way for rst_level. Falling edges produce no pulse.
- Registered outputs, updated at the same edge as the level change:
  - S <= set_rise & ~rst_level_next & ~rst_rise.
  - R <= rst_rise & ~set_level_next & ~set_rise.
  - conflict <= (set_rise & (rst_level_next | rst_rise)) | (rst_rise & (set_level_next | set_rise)).
  - *_next denotes the level value being written at that edge.
- Pulse width: S, R and conflict are high for exactly one cycle per qualifying event. S&R==1 is impossible.
- Boundaries:
  - Both buttons qualify on the same edge: no S, no R, conflict=1 for one cycle.
  - Second button pressed while the first is held: suppressed, conflict=1.
  - A held button never re-pulses.
  - Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: hold rst_n=0 for 3 cycles with buttons toggling -> S=R=set_level=rst_level=conflict=0 throughout. After release with buttons low, all outputs stay 0.
- Clean press: btn_set 0->1 sampled at edge k and held 20 cycles -> set_level=1 from edge k+5. S=1 for exactly the cycle after edge k+5, then 0 while held. R=0 throughout.
- Bounce: btn_set pattern 1,1,0,1,1,0,1 (one value per cycle), then steady 1 -> no level change during the pattern. set_level rises 5 edges after the final steady run begins. Exactly one S pulse.
- Interlock: hold btn_rst until rst_level=1, then press btn_set -> when set qualifies, S=0, R=0, conflict=1 for one cycle. Release btn_rst -> no pulses generated.
- Simultaneous: btn_set and btn_rst rise on the same edge -> both levels rise at edge k+5. S=R=0, conflict=1 for one cycle.
- Reset mid-count: btn_rst rises, then rst_n=0 for one cycle after 2 cycles, btn_rst held -> R pulses 5 edges after the first edge sampling btn_rst with rst_n=1, not earlier.
